// File: rtl/jk_drive_seq_if.sv
// jk_drive_seq_if: request handshake, JK drive and bank feedback bundle for jk_drive_seq.
interface jk_drive_seq_if #(parameter int WIDTH = 4);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_value;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_mask;
  modport master (
    output req_valid, req_value, q_fb,
    input  req_ready, j_out, k_out, busy, done, err, err_mask
  );
  modport slave (
    input  req_valid, req_value, q_fb,
    output req_ready, j_out, k_out, busy, done, err, err_mask
  );
endinterface

// File: rtl/jk_drive_seq.sv
// jk_drive_seq: drives a JK flip-flop bank towards a target word with set/reset pulses,
// verifies the Q feedback after a settle period and retries a bounded number of times.
module jk_drive_seq #(
  parameter int WIDTH     = 4,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 3
) (
  input logic           clk,
  input logic           rst,
  jk_drive_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, CHECK} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] target;
  logic [3:0]       retry_cnt;
  logic [3:0]       settle_cnt;
  logic             accept;
  logic             match;
  logic             retry;
  assign accept = bus.req_valid && (state == IDLE);
  assign match  = bus.q_fb == target;
  assign retry  = retry_cnt < 4'(MAX_RETRY);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = accept ? DRIVE : IDLE;
      DRIVE:   state_nx = WAIT;
      WAIT:    state_nx = (settle_cnt == 4'(SETTLE - 1)) ? CHECK : WAIT;
      CHECK:   state_nx = (!match && retry) ? DRIVE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.req_ready = state == IDLE;
    bus.busy      = state != IDLE;
  end
  // Drive words are only ever set/reset masks, so J and K cannot overlap on a bit.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.j_out    <= '0;
      bus.k_out    <= '0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.err_mask <= '0;
      target       <= '0;
      retry_cnt    <= '0;
      settle_cnt   <= '0;
    end else begin
      bus.j_out  <= '0;
      bus.k_out  <= '0;
      bus.done   <= (state == CHECK) && match;
      bus.err    <= (state == CHECK) && !match && !retry;
      settle_cnt <= (state == WAIT) ? settle_cnt + 4'd1 : 4'd0;
      if (accept) begin
        target       <= bus.req_value;
        retry_cnt    <= '0;
        bus.err_mask <= '0;
        bus.j_out    <= bus.req_value & ~bus.q_fb;
        bus.k_out    <= ~bus.req_value & bus.q_fb;
      end
      if ((state == CHECK) && !match) begin
        if (retry) begin
          retry_cnt <= retry_cnt + 4'd1;
          bus.j_out <= target & ~bus.q_fb;
          bus.k_out <= ~target & bus.q_fb;
        end else begin
          bus.err_mask <= target ^ bus.q_fb;
        end
      end
    end
endmodule

// File: tb/tb_jk_drive_seq.sv
// tb_jk_drive_seq: directed bench for jk_drive_seq with a behavioural JK bank that can
// model stuck-at-0 bits and drive pulses that are lost.
module tb_jk_drive_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] q = 4'b0000;
  logic [3:0] stuck0 = 4'b0000;
  logic       q_load = 1'b0;
  logic [3:0] q_load_val = 4'b0000;
  int         skip = 0;
  int         skip_load = 0;
  int         checks = 0;
  int         failures = 0;
  int         drive_cnt = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         cyc, d0, n0, e0;
  logic [3:0] vals [10];

  jk_drive_seq_if #(.WIDTH(4)) bus ();
  jk_drive_seq #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  assign bus.q_fb = q;

  always @(posedge clk)
    if (q_load) begin
      q    <= q_load_val;
      skip <= skip_load;
    end else if (|(bus.j_out | bus.k_out)) begin
      if (skip != 0) skip <= skip - 1;
      else           q <= ((q & ~bus.k_out) | bus.j_out) & ~stuck0;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("jk_overlap", 32'(bus.j_out & bus.k_out), 32'h0);
    chk("done_err_together", 32'(bus.done & bus.err), 32'h0);
    if (|(bus.j_out | bus.k_out)) drive_cnt++;
    if (bus.done) done_cnt++;
    if (bus.err) err_cnt++;
  endtask

  task automatic wait_end(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.done || bus.err) && n < max);
  endtask

  task automatic set_bank(input logic [3:0] v, input logic [3:0] st, input int sk);
    stuck0     = st;
    q_load_val = v;
    skip_load  = sk;
    q_load     = 1'b1;
    tick();
    q_load     = 1'b0;
  endtask

  initial begin
    vals = '{4'b1111, 4'b0101, 4'b1000, 4'b1100, 4'b0001,
             4'b0010, 4'b0100, 4'b0110, 4'b0111, 4'b1001};
    bus.req_valid = 1'b0;
    bus.req_value = 4'b0000;
    #2;
    chk("rst_ready", 32'(bus.req_ready), 32'h1);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_j", 32'(bus.j_out), 32'h0);
    chk("rst_k", 32'(bus.k_out), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_mask", 32'(bus.err_mask), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Plain set from all-zero bank.
    set_bank(4'b0000, 4'b0000, 0);
    d0 = drive_cnt; e0 = err_cnt;
    bus.req_value = 4'b1010;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("t2_j", 32'(bus.j_out), 32'hA);
    chk("t2_k", 32'(bus.k_out), 32'h0);
    chk("t2_busy", 32'(bus.busy), 32'h1);
    chk("t2_ready", 32'(bus.req_ready), 32'h0);
    wait_end(20, cyc);
    chk("t2_latency", 32'(cyc), 32'd3);
    chk("t2_done", 32'(bus.done), 32'h1);
    chk("t2_ready_in_done", 32'(bus.req_ready), 32'h1);
    chk("t2_q", 32'(q), 32'hA);
    chk("t2_pulses", 32'(drive_cnt - d0), 32'd1);
    chk("t2_no_err", 32'(err_cnt - e0), 32'd0);
    tick();
    chk("t2_done_pulse", 32'(bus.done), 32'h0);

    // Mixed set and reset bits.
    set_bank(4'b1100, 4'b0000, 0);
    bus.req_value = 4'b0110;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("t3_j", 32'(bus.j_out), 32'h2);
    chk("t3_k", 32'(bus.k_out), 32'h8);
    wait_end(20, cyc);
    chk("t3_latency", 32'(cyc), 32'd3);
    chk("t3_done", 32'(bus.done), 32'h1);
    chk("t3_q", 32'(q), 32'h6);

    // Bit 0 stuck at zero exhausts all four attempts.
    set_bank(4'b0000, 4'b0001, 0);
    d0 = drive_cnt; n0 = done_cnt; e0 = err_cnt;
    bus.req_value = 4'b0001;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("t4_j", 32'(bus.j_out), 32'h1);
    wait_end(40, cyc);
    chk("t4_latency", 32'(cyc), 32'd12);
    chk("t4_err", 32'(bus.err), 32'h1);
    chk("t4_done", 32'(bus.done), 32'h0);
    chk("t4_mask", 32'(bus.err_mask), 32'h1);
    chk("t4_pulses", 32'(drive_cnt - d0), 32'd4);
    tick();
    chk("t4_err_pulse", 32'(bus.err), 32'h0);
    chk("t4_mask_held", 32'(bus.err_mask), 32'h1);
    chk("t4_err_count", 32'(err_cnt - e0), 32'd1);
    chk("t4_done_count", 32'(done_cnt - n0), 32'd0);

    // First pulse lost, retry succeeds.
    set_bank(4'b0000, 4'b0000, 1);
    d0 = drive_cnt; e0 = err_cnt;
    bus.req_value = 4'b0100;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("t5_mask_cleared", 32'(bus.err_mask), 32'h0);
    wait_end(40, cyc);
    chk("t5_latency", 32'(cyc), 32'd6);
    chk("t5_done", 32'(bus.done), 32'h1);
    chk("t5_mask", 32'(bus.err_mask), 32'h0);
    chk("t5_pulses", 32'(drive_cnt - d0), 32'd2);
    chk("t5_no_err", 32'(err_cnt - e0), 32'd0);
    chk("t5_q", 32'(q), 32'h4);

    // Asynchronous reset in the middle of a drive pulse.
    set_bank(4'b0000, 4'b0000, 0);
    bus.req_value = 4'b1010;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    chk("t1_j_before", 32'(bus.j_out), 32'hA);
    #2 rst = 1'b0;
    #1;
    chk("t1_j", 32'(bus.j_out), 32'h0);
    chk("t1_k", 32'(bus.k_out), 32'h0);
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    chk("t1_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("t1_idle_after", 32'(bus.req_ready), 32'h1);
    chk("t1_q_untouched", 32'(q), 32'h0);

    // Valid held for ten cycles: values offered while busy are ignored.
    set_bank(4'b0000, 4'b0000, 0);
    n0 = done_cnt;
    bus.req_value = 4'b0011;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        chk("t6_j0", 32'(bus.j_out), 32'h3);
        chk("t6_k0", 32'(bus.k_out), 32'h0);
      end
      if (i == 1 || i == 2) chk("t6_ignored_j", 32'(bus.j_out), 32'h0);
      if (i == 3) begin
        chk("t6_done1", 32'(bus.done), 32'h1);
        chk("t6_q1", 32'(q), 32'h3);
        chk("t6_ready1", 32'(bus.req_ready), 32'h1);
      end
      if (i == 4) begin
        chk("t6_j1", 32'(bus.j_out), 32'hC);
        chk("t6_k1", 32'(bus.k_out), 32'h3);
      end
      if (i == 7) chk("t6_done2", 32'(bus.done), 32'h1);
      if (i == 8) begin
        chk("t6_j2", 32'(bus.j_out), 32'h2);
        chk("t6_k2", 32'(bus.k_out), 32'h8);
      end
      bus.req_value = vals[i];
    end
    bus.req_valid = 1'b0;
    wait_end(20, cyc);
    chk("t6_latency3", 32'(cyc), 32'd2);
    chk("t6_done3", 32'(bus.done), 32'h1);
    chk("t6_q3", 32'(q), 32'h6);
    chk("t6_done_count", 32'(done_cnt - n0), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
